// File: rtl/memory_matrix_pkg.sv
// Shared definitions for the memory-matrix level sequencer: FSM state
// encoding, board LFSR tap mask, level ceiling and a popcount helper.
package memory_matrix_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GEN   = 3'd1,
        ST_SHOW  = 3'd2,
        ST_PLAY  = 3'd3,
        ST_CHECK = 3'd4,
        ST_WIN   = 3'd5,
        ST_LOSE  = 3'd6
    } state_t;

    // x^8 + x^6 + x^5 + x^4 + 1 as a Fibonacci tap mask on bits 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Highest level; the board for level L carries L+2 tiles.
    localparam logic [2:0] MAX_LEVEL = 3'd5;

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/board_lfsr.sv
// 8-bit Fibonacci LFSR that generates candidate boards. The register is
// loaded with SEED on reset and steps once per cycle while en is high.
// next_value is the value the register will take on the next enabled edge,
// so the caller can test and latch a candidate in the same cycle it is made.
module board_lfsr
    import memory_matrix_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic [7:0] next_value
);

    logic [7:0] lfsr_q;

    assign next_value = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};

    // Seed on reset, advance only while enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= SEED;
        end else if (en) begin
            lfsr_q <= next_value;
        end
    end

endmodule

// File: rtl/level_sequencer.sv
// Level sequencer for a memory-matrix game: generates a board, shows it,
// collects tile guesses, and tracks level, mistakes and score.
// Optional build macro LEVEL_SEQ_TIMEOUT_EN adds a PLAY inactivity timeout
// that is scored as a wrong guess.
//
// Input strobes: start, give_up and guess_valid are single-cycle pulses
// sampled on the rising edge; there is no backpressure. A strobe that
// arrives in a state that does not consume it is dropped, and give_up
// wins over a guess_valid presented in the same PLAY cycle.
module level_sequencer
    import memory_matrix_pkg::*;
#(
    parameter int         DISPLAY_CYCLES = 50000000,
    parameter int         FLASH_CYCLES   = 12500000,
    parameter int         MAX_MISTAKES   = 3,
    parameter logic [7:0] LFSR_SEED      = 8'hA5
`ifdef LEVEL_SEQ_TIMEOUT_EN
    ,
    parameter int         PLAY_TIMEOUT_CYCLES = 250000000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       give_up,
    input  logic [7:0] guess,
    input  logic       guess_valid,
    output logic [7:0] board,
    output logic       ld_display,
    output logic       ld_play,
    output logic       ld_flash,
    output logic [2:0] level,
    output logic [3:0] mistakes,
    output logic [7:0] score,
    output logic       game_over,
    output state_t     fsm_state
);

    localparam logic [31:0] SHOW_LAST     = 32'(DISPLAY_CYCLES - 1);
    localparam logic [31:0] FLASH_LAST    = 32'(FLASH_CYCLES - 1);
    localparam logic [3:0]  MISTAKE_LIMIT = 4'(MAX_MISTAKES);
`ifdef LEVEL_SEQ_TIMEOUT_EN
    localparam logic [31:0] PLAY_LAST     = 32'(PLAY_TIMEOUT_CYCLES - 1);
`endif

    state_t      state_q, state_d;
    logic [31:0] timer_q;
    logic [7:0]  guess_q;
    logic [7:0]  guess_in;
    logic [7:0]  found_q;
    logic [7:0]  lfsr_next;

    // Control decoded from the FSM.
    logic        new_game;
    logic        ld_board;
    logic        ld_guess;
    logic        do_check;
    logic        next_level;

    // Results of judging the registered guess.
    logic        guess_hit;
    logic [7:0]  found_d;
    logic [3:0]  mistakes_d;
    logic [7:0]  score_d;
    logic [8:0]  score_sum;

    assign fsm_state = state_q;

    board_lfsr #(
        .SEED (LFSR_SEED)
    ) u_board_lfsr (
        .clk        (clk),
        .reset      (reset),
        .en         (state_q == ST_GEN),
        .next_value (lfsr_next)
    );

    // A guess hits when it touches the board and nothing outside it.
    assign guess_hit = ((guess_q & board) != 8'd0) && ((guess_q & ~board) == 8'd0);

    // Updated found/mistakes/score as they would be after this CHECK.
    always_comb begin
        found_d    = found_q;
        mistakes_d = mistakes;
        score_d    = score;
        score_sum  = {1'b0, score} + {5'd0, popcount(guess_q & ~found_q)};
        if (guess_hit) begin
            found_d = found_q | guess_q;
            score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
        end else begin
            mistakes_d = mistakes + 4'd1;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_d    = state_q;
        new_game   = 1'b0;
        ld_board   = 1'b0;
        ld_guess   = 1'b0;
        guess_in   = guess;
        do_check   = 1'b0;
        next_level = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    new_game = 1'b1;
                    state_d  = ST_GEN;
                end
            end
            ST_GEN: begin
                if (popcount(lfsr_next) == ({1'b0, level} + 4'd2)) begin
                    ld_board = 1'b1;
                    state_d  = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (timer_q == SHOW_LAST) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (give_up) begin
                    state_d = ST_LOSE;
                end else if (guess_valid) begin
                    ld_guess = 1'b1;
                    state_d  = ST_CHECK;
                end
`ifdef LEVEL_SEQ_TIMEOUT_EN
                else if (timer_q == PLAY_LAST) begin
                    // An empty guess never touches the board, so CHECK scores it wrong.
                    ld_guess = 1'b1;
                    guess_in = 8'd0;
                    state_d  = ST_CHECK;
                end
`endif
            end
            ST_CHECK: begin
                do_check = 1'b1;
                if (found_d == board) begin
                    state_d = ST_WIN;
                end else if (mistakes_d == MISTAKE_LIMIT) begin
                    state_d = ST_LOSE;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_WIN: begin
                if (timer_q == FLASH_LAST) begin
                    next_level = 1'b1;
                    state_d    = ST_GEN;
                end
            end
            ST_LOSE: begin
                if (start) begin
                    new_game = 1'b1;
                    state_d  = ST_GEN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Dwell timer: restarts on every state change, counts otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q <= 32'd0;
        end else if (state_d != state_q) begin
            timer_q <= 32'd0;
        end else begin
            timer_q <= timer_q + 32'd1;
        end
    end

    // Game datapath: board, guess, found tiles, level, mistakes, score.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            board    <= 8'd0;
            guess_q  <= 8'd0;
            found_q  <= 8'd0;
            level    <= 3'd0;
            mistakes <= 4'd0;
            score    <= 8'd0;
        end else begin
            if (new_game) begin
                found_q  <= 8'd0;
                level    <= 3'd0;
                mistakes <= 4'd0;
                score    <= 8'd0;
            end
            if (ld_board) begin
                board <= lfsr_next;
            end
            if (ld_guess) begin
                guess_q <= guess_in;
            end
            if (do_check) begin
                found_q  <= found_d;
                mistakes <= mistakes_d;
                score    <= score_d;
            end
            if (next_level) begin
                level    <= (level == MAX_LEVEL) ? level : level + 3'd1;
                found_q  <= 8'd0;
                mistakes <= 4'd0;
            end
        end
    end

    // Phase strobes follow the state one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_display <= 1'b0;
            ld_play    <= 1'b0;
            ld_flash   <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            ld_display <= (state_q == ST_SHOW) || (state_q == ST_LOSE);
            ld_play    <= (state_q == ST_PLAY);
            ld_flash   <= (state_q == ST_WIN) || (state_q == ST_LOSE);
            game_over  <= (state_q == ST_LOSE);
        end
    end

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer with short display/flash times.
// Boards are predicted by an independent LFSR model in the bench.
module tb_level_sequencer;
    import memory_matrix_pkg::*;

    localparam int         DISP  = 4;
    localparam int         FLASH = 2;
    localparam int         MAXM  = 3;
    localparam logic [7:0] SEED  = 8'hA5;

    // Wait targets / expected outcome of a table step.
    localparam int W_PLAY = 0;
    localparam int W_SHOW = 1;
    localparam int W_LOSE = 2;

    // Guess kinds, derived from the expected board.
    localparam int K_LO    = 0;  // lowest board tile
    localparam int K_HI    = 1;  // all board tiles except the lowest
    localparam int K_FULL  = 2;  // whole board
    localparam int K_OUT   = 3;  // lowest tile plus a tile off the board
    localparam int K_ZERO  = 4;  // empty guess
    localparam int K_START = 5;  // start pulse instead of a guess

    typedef struct {
        int         kind;
        logic       gu;
        int         outcome;
        logic [3:0] mis;
        logic [7:0] score;
        logic [2:0] lvl;
    } vec_t;

    localparam int NV = 13;

    logic       clk;
    logic       reset;
    logic       start;
    logic       give_up;
    logic [7:0] guess;
    logic       guess_valid;
    logic [7:0] board;
    logic       ld_display;
    logic       ld_play;
    logic       ld_flash;
    logic [2:0] level;
    logic [3:0] mistakes;
    logic [7:0] score;
    logic       game_over;
    state_t     fsm_state;

    int         total;
    int         bad;
    logic [7:0] exp_q[$];
    logic [7:0] m_lfsr;
    logic [7:0] cur_board;
    vec_t       vecs[NV];

    level_sequencer #(
        .DISPLAY_CYCLES (DISP),
        .FLASH_CYCLES   (FLASH),
        .MAX_MISTAKES   (MAXM),
        .LFSR_SEED      (SEED)
`ifdef LEVEL_SEQ_TIMEOUT_EN
        ,
        .PLAY_TIMEOUT_CYCLES (10)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .give_up     (give_up),
        .guess       (guess),
        .guess_valid (guess_valid),
        .board       (board),
        .ld_display  (ld_display),
        .ld_play     (ld_play),
        .ld_flash    (ld_flash),
        .level       (level),
        .mistakes    (mistakes),
        .score       (score),
        .game_over   (game_over),
        .fsm_state   (fsm_state)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        logic fb;
        fb = v[7] ^ v[5] ^ v[4] ^ v[3];
        return {v[6:0], fb};
    endfunction

    function automatic int pop8(input logic [7:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    function automatic logic [7:0] make_guess(input int kind, input logic [7:0] b);
        logic [7:0] lo;
        logic [7:0] nb;
        logic [7:0] outb;
        lo   = b & (~b + 8'd1);
        nb   = ~b;
        outb = nb & (~nb + 8'd1);
        case (kind)
            K_LO:    return lo;
            K_HI:    return b & ~lo;
            K_FULL:  return b;
            K_OUT:   return lo | outb;
            default: return 8'd0;
        endcase
    endfunction

    // Scoreboard comparison.
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Predict the next board for a level and queue it.
    task automatic model_gen(input int lvl);
        m_lfsr = lfsr_step(m_lfsr);
        while (pop8(m_lfsr) != lvl + 2) begin
            m_lfsr = lfsr_step(m_lfsr);
        end
        exp_q.push_back(m_lfsr);
    endtask

    task automatic check_board(input string name);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got board %0h expected none queued", name, board);
        end else begin
            cur_board = exp_q.pop_front();
            check(name, 32'(board), 32'(cur_board));
        end
    endtask

    // Bounded wait, polled on the falling edge.
    task automatic wait_for(input int what, input string name);
        int n;
        bit hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 3000) begin
            case (what)
                W_PLAY:  hit = (ld_play === 1'b1);
                W_SHOW:  hit = (ld_display === 1'b1) && (game_over === 1'b0);
                default: hit = (game_over === 1'b1);
            endcase
            if (!hit) begin
                @(negedge clk);
                n++;
            end
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL %s: got no strobe expected strobe %0d within 3000 cycles", name, what);
        end
    endtask

    // Driver: one guess pulse (optionally with give_up) on a falling edge.
    task automatic drive_guess(input logic [7:0] g, input logic gu);
        guess       = g;
        guess_valid = 1'b1;
        give_up     = gu;
        @(negedge clk);
        guess       = 8'd0;
        guess_valid = 1'b0;
        give_up     = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        vec_t v;
        int   cnt;
        int   exp_lvl;
        int   exp_score;

        total = 0;
        bad   = 0;
        reset = 1'b0;
        start = 1'b0;
        give_up = 1'b0;
        guess = 8'd0;
        guess_valid = 1'b0;
        m_lfsr = SEED;

        //              kind     gu    outcome  mis   score  lvl
        vecs[0]  = '{K_LO,    1'b0, W_PLAY, 4'd0, 8'd1, 3'd0};
        vecs[1]  = '{K_LO,    1'b0, W_PLAY, 4'd0, 8'd1, 3'd0};  // re-guess found tile
        vecs[2]  = '{K_OUT,   1'b0, W_PLAY, 4'd1, 8'd1, 3'd0};
        vecs[3]  = '{K_HI,    1'b0, W_SHOW, 4'd0, 8'd2, 3'd1};  // completes board
        vecs[4]  = '{K_FULL,  1'b0, W_SHOW, 4'd0, 8'd5, 3'd2};
        vecs[5]  = '{K_OUT,   1'b0, W_PLAY, 4'd1, 8'd5, 3'd2};
        vecs[6]  = '{K_OUT,   1'b0, W_PLAY, 4'd2, 8'd5, 3'd2};
        vecs[7]  = '{K_OUT,   1'b0, W_LOSE, 4'd3, 8'd5, 3'd2};
        vecs[8]  = '{K_START, 1'b0, W_SHOW, 4'd0, 8'd0, 3'd0};
        vecs[9]  = '{K_FULL,  1'b1, W_LOSE, 4'd0, 8'd0, 3'd0};  // give_up beats guess
        vecs[10] = '{K_START, 1'b0, W_SHOW, 4'd0, 8'd0, 3'd0};
        vecs[11] = '{K_ZERO,  1'b0, W_PLAY, 4'd1, 8'd0, 3'd0};
        vecs[12] = '{K_LO,    1'b0, W_PLAY, 4'd1, 8'd1, 3'd0};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
        check("rst_board", 32'(board), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_mis", 32'(mistakes), 32'd0);
        check("rst_score", 32'(score), 32'd0);
        check("rst_strobes", 32'({ld_display, ld_play, ld_flash, game_over}), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // First game: board popcount 2 and display length.
        pulse_start();
        model_gen(0);
        wait_for(W_SHOW, "first_show");
        check_board("board_l0");
        check("pop_l0", 32'(pop8(board)), 32'd2);
        cnt = 0;
        while (ld_display === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("display_len", 32'(cnt), 32'(DISP));
        check("play_after_show", 32'(ld_play), 32'd1);

        // Table-driven guesses.
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            if (v.kind == K_START) begin
                pulse_start();
            end else begin
                wait_for(W_PLAY, $sformatf("v%0d_play", i));
                drive_guess(make_guess(v.kind, cur_board), v.gu);
            end
            @(negedge clk);
            if (v.outcome == W_SHOW) model_gen(int'(v.lvl));
            wait_for(v.outcome, $sformatf("v%0d_outcome", i));
            if (v.outcome == W_SHOW) check_board($sformatf("v%0d_board", i));
            check($sformatf("v%0d_mis", i), 32'(mistakes), 32'(v.mis));
            check($sformatf("v%0d_score", i), 32'(score), 32'(v.score));
            check($sformatf("v%0d_level", i), 32'(level), 32'(v.lvl));
            check($sformatf("v%0d_over", i), 32'(game_over), 32'(v.outcome == W_LOSE));
            if (v.outcome == W_LOSE) begin
                check($sformatf("v%0d_lose_disp", i), 32'(ld_display), 32'd1);
                check($sformatf("v%0d_lose_flash", i), 32'(ld_flash), 32'd1);
            end
        end

        // start in PLAY is ignored.
        pulse_start();
        repeat (2) @(negedge clk);
        check("start_in_play_state", 32'(fsm_state), 32'(ST_PLAY));
        check("start_in_play_mis", 32'(mistakes), 32'd1);
        check("start_in_play_score", 32'(score), 32'd1);

        // Finish the board, then strobe guess+give_up during SHOW: ignored.
        wait_for(W_PLAY, "c_play");
        drive_guess(make_guess(K_HI, cur_board), 1'b0);
        @(negedge clk);
        model_gen(1);
        wait_for(W_SHOW, "c_show");
        check_board("c_board");
        drive_guess(cur_board, 1'b1);
        wait_for(W_PLAY, "c_play_after");
        check("c_mis", 32'(mistakes), 32'd0);
        check("c_score", 32'(score), 32'd2);
        check("c_level", 32'(level), 32'd1);
        check("c_over", 32'(game_over), 32'd0);

        // Reset asserted during SHOW aborts the round.
        drive_guess(cur_board, 1'b0);
        @(negedge clk);
        model_gen(2);
        wait_for(W_SHOW, "d_show");
        check_board("d_board");
        reset = 1'b0;
        #1;
        check("d_rst_state", 32'(fsm_state), 32'(ST_IDLE));
        check("d_rst_board", 32'(board), 32'd0);
        check("d_rst_level", 32'(level), 32'd0);
        check("d_rst_score", 32'(score), 32'd0);
        check("d_rst_mis", 32'(mistakes), 32'd0);
        check("d_rst_strobes", 32'({ld_display, ld_play, ld_flash, game_over}), 32'd0);
        m_lfsr = SEED;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Level saturates at 5 across repeated wins.
        pulse_start();
        exp_score = 0;
        for (int i = 0; i < 7; i++) begin
            exp_lvl = (i > 5) ? 5 : i;
            model_gen(exp_lvl);
            wait_for(W_SHOW, $sformatf("e%0d_show", i));
            check_board($sformatf("e%0d_board", i));
            check($sformatf("e%0d_level", i), 32'(level), 32'(exp_lvl));
            if (i < 6) begin
                wait_for(W_PLAY, $sformatf("e%0d_play", i));
                drive_guess(cur_board, 1'b0);
                exp_score = exp_score + exp_lvl + 2;
            end
        end
        check("e_score", 32'(score), 32'(exp_score));

        // Idle in PLAY: timeout scores a mistake only when built in.
        wait_for(W_PLAY, "f_play");
        repeat (12) @(negedge clk);
`ifdef LEVEL_SEQ_TIMEOUT_EN
        check("f_timeout_mis", 32'(mistakes), 32'd1);
`else
        check("f_no_timeout_mis", 32'(mistakes), 32'd0);
`endif
        check("f_play", 32'(ld_play), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
